// File: rtl/rot_seq.sv
// Rotate sequencer: breaks an N-position rotate into N single-bit requests
// to an external rotate unit, handshaking on its busy flag with a timeout.
module rot_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       dir,
  input  logic [2:0] amt,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       err,
  output logic [7:0] rot_in,
  output logic [2:0] rot_cntrl,
  output logic [3:0] rot_ctr2,
  input  logic       rot_ctr,
  input  logic [7:0] rot_out
);

  // state   | meaning
  // IDLE    | waiting for start
  // ISSUE   | one-cycle request to the rotate unit
  // WAIT_HI | waiting for the rotate unit to raise busy
  // WAIT_LO | waiting for the rotate unit to drop busy
  // FINISH  | done pulse, dout valid

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, FINISH} state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] acc, acc_nxt;
  logic       dir_q, dir_nxt;
  logic [2:0] rem, rem_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       err_q, err_nxt;
  logic [7:0] dout_q, dout_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= 8'h00;
      dir_q  <= 1'b0;
      rem    <= 3'd0;
      wcnt   <= 4'd0;
      err_q  <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      dir_q  <= dir_nxt;
      rem    <= rem_nxt;
      wcnt   <= wcnt_nxt;
      err_q  <= err_nxt;
      dout_q <= dout_nxt;
    end
  end

  // dout is loaded on the edge entering FINISH so it is valid alongside done.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    dir_nxt   = dir_q;
    rem_nxt   = rem;
    wcnt_nxt  = wcnt;
    err_nxt   = err_q;
    dout_nxt  = dout_q;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt = din;
          dir_nxt = dir;
          rem_nxt = amt;
          err_nxt = 1'b0;
          if (amt == 3'd0) begin
            dout_nxt  = din;
            state_nxt = FINISH;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        wcnt_nxt  = 4'd0;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (rot_ctr) begin
          acc_nxt   = rot_out;
          wcnt_nxt  = 4'd0;
          state_nxt = WAIT_LO;
        end else if (wcnt == TMO_LAST) begin
          err_nxt   = 1'b1;
          dout_nxt  = acc;
          state_nxt = FINISH;
        end else begin
          wcnt_nxt = wcnt + 4'd1;
        end
      end
      WAIT_LO: begin
        if (!rot_ctr) begin
          rem_nxt = rem - 3'd1;
          if (rem == 3'd1) begin
            dout_nxt  = acc;
            state_nxt = FINISH;
          end else begin
            state_nxt = ISSUE;
          end
        end else if (wcnt == TMO_LAST) begin
          err_nxt   = 1'b1;
          dout_nxt  = acc;
          state_nxt = FINISH;
        end else begin
          wcnt_nxt = wcnt + 4'd1;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request lines idle at "no request" outside ISSUE so a held unit never re-fires.
  always_comb begin
    rot_ctr2  = 4'b1111;
    rot_in    = 8'h00;
    rot_cntrl = 3'b000;
    if (state == ISSUE) begin
      rot_ctr2  = 4'b0000;
      rot_in    = acc;
      rot_cntrl = {2'b00, dir_q};
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);
  assign dout = dout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rot_seq.sv
// Randomized self-checking bench for rot_seq with a behavioural rotate-unit
// responder and an arithmetic reference for results and edge timing.
module tb_rot_seq;

  localparam int TMO = 15;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] din;
  logic       dir;
  logic [2:0] amt;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       err;
  logic [7:0] rot_in;
  logic [2:0] rot_cntrl;
  logic [3:0] rot_ctr2;
  logic       rot_ctr;
  logic [7:0] rot_out;

  int n_chk = 0;
  int n_err = 0;
  int hold_len = 3;
  int hold_cnt;

  rot_seq #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .dir(dir), .amt(amt),
    .busy(busy), .done(done), .dout(dout), .err(err),
    .rot_in(rot_in), .rot_cntrl(rot_cntrl), .rot_ctr2(rot_ctr2),
    .rot_ctr(rot_ctr), .rot_out(rot_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate unit: one-bit rotate, busy held for hold_len cycles after a request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 0;
      rot_out  <= 8'h00;
    end else if (rot_ctr2 == 4'b0000 && hold_len > 0) begin
      hold_cnt <= hold_len;
      rot_out  <= rot_cntrl[0] ? {rot_in[0], rot_in[7:1]} : {rot_in[6:0], rot_in[7]};
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
    end
  end
  assign rot_ctr = (hold_cnt > 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic dr, input int a);
    logic [15:0] x;
    x = {d, d};
    if (dr) begin
      x = x >> a;
      return x[7:0];
    end
    x = x << a;
    return x[15:8];
  endfunction

  task automatic run_op(input logic [7:0] d, input logic dr, input logic [2:0] a, input int h,
                        input logic exp_err, input logic [7:0] exp_dout, input int exp_edges,
                        input int exp_issues, input bit repulse);
    int edges;
    int issues;
    hold_len = h;
    @(negedge clk);
    din = d; dir = dr; amt = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_clr", {31'd0, err}, 32'd0);
    edges = 0;
    issues = 0;
    while (!done && edges < 300) begin
      chk("busy_op", {31'd0, busy}, 32'd1);
      if (rot_ctr2 == 4'b0000) begin
        chk("rot_in", {24'd0, rot_in}, {24'd0, ref_rot(d, dr, issues)});
        chk("rot_cntrl", {29'd0, rot_cntrl}, {31'd0, dr});
        issues++;
      end
      if (repulse && edges == 2) begin
        start = 1'b1; din = ~d; dir = ~dr; amt = 3'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    chk("done", {31'd0, done}, 32'd1);
    chk("edges", edges, exp_edges);
    chk("issues", issues, exp_issues);
    chk("dout", {24'd0, dout}, {24'd0, exp_dout});
    chk("err", {31'd0, err}, {31'd0, exp_err});
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("dout_hold", {24'd0, dout}, {24'd0, exp_dout});
    chk("err_hold", {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_dout"}, {24'd0, dout}, 32'd0);
    chk({tag, "_rot_in"}, {24'd0, rot_in}, 32'd0);
    chk({tag, "_rot_cntrl"}, {29'd0, rot_cntrl}, 32'd0);
    chk({tag, "_rot_ctr2"}, {28'd0, rot_ctr2}, 32'hF);
  endtask

  initial begin
    logic [7:0] d;
    logic       dr;
    logic [2:0] a;
    int         h;
    int         dcount;

    rst_n = 1'b0; start = 1'b0; din = 8'h00; dir = 1'b0; amt = 3'd0;
    #3;
    chk_reset_outputs("rst0");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hB1, 1'b0, 3'd1, 3, 1'b0, 8'h63, 5, 1, 1'b0);
    run_op(8'h81, 1'b1, 3'd3, 3, 1'b0, 8'h30, 15, 3, 1'b0);
    run_op(8'h5A, 1'b0, 3'd0, 3, 1'b0, 8'h5A, 0, 0, 1'b0);

    // rotate unit never answers: abort out of WAIT_HI with the operand untouched
    d = 8'($urandom);
    run_op(d, 1'b1, 3'd2, 0, 1'b1, d, 1 + TMO, 1, 1'b0);

    // rotate unit sticks busy: abort out of WAIT_LO after one rotation
    d = 8'($urandom);
    run_op(d, 1'b0, 3'd3, 40, 1'b1, ref_rot(d, 1'b0, 1), 2 + TMO, 1, 1'b0);
    repeat (45) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom);
      dr = 1'($urandom);
      a  = 3'($urandom);
      h  = $urandom_range(1, 4);
      run_op(d, dr, a, h, 1'b0, ref_rot(d, dr, a), (h + 2) * a, a, 1'b0);
    end

    run_op(8'hC3, 1'b1, 3'd2, 3, 1'b0, ref_rot(8'hC3, 1'b1, 2), 10, 2, 1'b1);
    dcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("no_extra_done", dcount, 0);

    // reset asserted while in WAIT_LO
    hold_len = 3;
    @(negedge clk);
    din = 8'h81; dir = 1'b1; amt = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    dcount = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("rst_quiet", dcount, 0);

    // start accepted on the first edge after reset release
    din = 8'h5A; dir = 1'b0; amt = 3'd0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_rst_done", {31'd0, done}, 32'd1);
    chk("post_rst_dout", {24'd0, dout}, 32'h5A);
    @(posedge clk); #1;
    chk("post_rst_pulse", {31'd0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
